// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed access latency and pipeline stall.
// Optional alignment checking is built only when DMEM_ALIGN_CHK_EN is defined.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

  stateE             state;
  stateE             nextState;
  logic [3:0]        countdown;
  logic              weQ;
  logic [IdxW+1:0]   addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enterResp;
  logic              accWe;
  logic [IdxW+1:0]   accAddr;
  logic [IdxW-1:0]   accIdx;
  logic [31:0]       accWdata;
  logic              alignErr;
  logic              unusedBits;

  assign accept = req_valid & req_ready;

  // With LATENCY==1 the access happens on the accept edge itself, so the
  // live request feeds the access path while still in IDLE.
  assign accWe    = (state == IDLE) ? req_we : weQ;
  assign accAddr  = (state == IDLE) ? req_addr[IdxW+1:0] : addrQ;
  assign accWdata = (state == IDLE) ? req_wdata : wdataQ;
  assign accIdx   = accAddr[IdxW+1:2];

  assign unusedBits = ^{req_addr[31:IdxW+2], accAddr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  assign alignErr = (accAddr[1:0] != 2'b00);
`else
  assign alignErr = 1'b0;
`endif

  // Gating with rst keeps a store from landing while reset is held.
  assign enterResp = rst & (nextState == RESP) & (state != RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      countdown  <= 4'd0;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      resp_rdata <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        weQ       <= req_we;
        addrQ     <= req_addr[IdxW+1:0];
        wdataQ    <= req_wdata;
        countdown <= 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
      end else if (state == WAIT && countdown != 4'd0) begin
        countdown <= countdown - 4'd1;
      end
      if (enterResp) begin
        resp_rdata <= (accWe || alignErr) ? 32'd0 : mem[accIdx];
      end
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_err <= 1'b0;
    end else if (enterResp) begin
      resp_err <= alignErr;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (enterResp && accWe && !alignErr) begin
      mem[accIdx] <= accWdata;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (countdown == 4'd0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  assign stall = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder at LATENCY 2, 1 and 3.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [2:0]  respValid;
  logic [31:0] respRdata [3];
  logic [2:0]  respErr;
  logic [2:0]  stall;

  int compared;
  int mismatched;

  logic [31:0] rdata;
  logic        err;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dutL2 (
    .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dutL1 (
    .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1]),
    .stall(stall[1])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(3)) dutL3 (
    .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid[2]), .resp_rdata(respRdata[2]), .resp_err(respErr[2]),
    .stall(stall[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance w; inputs are scrambled after the accept
  // edge to show the request was latched.
  task automatic doReq(input int w, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input string tag,
                       output logic [31:0] rdOut, output logic errOut);
    int n;
    reqWe       = we;
    reqAddr     = addr;
    reqWdata    = wdata;
    reqValid[w] = 1'b1;
    check({tag, "_ready"}, 32'(reqReady[w]), 32'd1);
    tick();
    reqWe    = ~we;
    reqAddr  = 32'hFFFF_FFFC;
    reqWdata = 32'h0BAD_0BAD;
    n = 1;
    while (!respValid[w] && n < 20) begin
      check({tag, "_stall"}, 32'(stall[w]), 32'd1);
      check({tag, "_busy"}, 32'(reqReady[w]), 32'd0);
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_rstall"}, 32'(stall[w]), 32'd0);
    rdOut       = respRdata[w];
    errOut      = respErr[w];
    reqValid[w] = 1'b0;
    tick();
    check({tag, "_pulse"}, 32'(respValid[w]), 32'd0);
    check({tag, "_idle"}, 32'(reqReady[w]), 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    reqValid   = 3'b111;
    reqWe      = 1'b1;
    reqAddr    = 32'h10;
    reqWdata   = 32'h9999_9999;

    // Reset held with requests pending: nothing may be accepted.
    repeat (3) tick();
    for (int w = 0; w < 3; w++) begin
      check("rst_ready", 32'(reqReady[w]), 32'd1);
      check("rst_valid", 32'(respValid[w]), 32'd0);
      check("rst_rdata", respRdata[w], 32'd0);
      check("rst_stall", 32'(stall[w]), 32'd1);
    end
    reqValid = 3'b000;
    rst      = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      check("post_rst_valid", 32'(respValid[w]), 32'd0);
      check("post_rst_ready", 32'(reqReady[w]), 32'd1);
    end

    // LATENCY=2 store then load.
    doReq(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, "l2_st", rdata, err);
    check("l2_st_rdata", rdata, 32'd0);
    check("l2_st_err", 32'(err), 32'd0);
    doReq(0, 1'b0, 32'h10, 32'h0, 2, "l2_ld", rdata, err);
    check("l2_ld_rdata", rdata, 32'hDEAD_BEEF);

    // LATENCY=1 index wrap: 0x1000 aliases word 0.
    doReq(1, 1'b1, 32'h1000, 32'h1234, 1, "l1_st", rdata, err);
    check("l1_st_rdata", rdata, 32'd0);
    doReq(1, 1'b0, 32'h0, 32'h0, 1, "l1_ld", rdata, err);
    check("l1_wrap_rdata", rdata, 32'h1234);

    // LATENCY=3 stall profile and latching.
    doReq(2, 1'b1, 32'h40, 32'h5555_AAAA, 3, "l3_st", rdata, err);
    doReq(2, 1'b0, 32'h40, 32'h0, 3, "l3_ld", rdata, err);
    check("l3_ld_rdata", rdata, 32'h5555_AAAA);

    // Reset during WAIT discards the pending store.
    doReq(0, 1'b1, 32'h20, 32'h1111_1111, 2, "l2_pre", rdata, err);
    reqWe       = 1'b1;
    reqAddr     = 32'h20;
    reqWdata    = 32'hA5A5_A5A5;
    reqValid[0] = 1'b1;
    tick();
    check("mid_wait_busy", 32'(reqReady[0]), 32'd0);
    reqValid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(reqReady[0]), 32'd1);
    check("mid_rst_rdata", respRdata[0], 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_novalid", 32'(respValid[0]), 32'd0);
    tick();
    check("mid_rst_novalid2", 32'(respValid[0]), 32'd0);
    doReq(0, 1'b0, 32'h20, 32'h0, 2, "l2_after", rdata, err);
    check("mid_rst_kept", rdata, 32'h1111_1111);

    // Misaligned store.
    doReq(0, 1'b1, 32'h22, 32'hFFFF_FFFF, 2, "l2_mis", rdata, err);
    check("mis_rdata", rdata, 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
    check("mis_err", 32'(err), 32'd1);
    doReq(0, 1'b0, 32'h20, 32'h0, 2, "l2_mis_ld", rdata, err);
    check("mis_ld_rdata", rdata, 32'h1111_1111);
    check("mis_ld_err", 32'(err), 32'd0);
`else
    check("mis_err", 32'(err), 32'd0);
    doReq(0, 1'b0, 32'h20, 32'h0, 2, "l2_mis_ld", rdata, err);
    check("mis_ld_rdata", rdata, 32'hFFFF_FFFF);
    check("mis_ld_err", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
